hdc_classify_ctrl: RTL and testbench



---
 rtl/hdc_classify_ctrl_if.sv | 47 ++++
 rtl/hdc_classify_ctrl.sv | 136 +++++++++++++
 tb/tb_hdc_classify_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdc_classify_ctrl_if.sv
// Query/memory/min-search/result bus of the HDC classification sequencer.
// HDC_CTRL_DIST_OUT_EN adds the res_dist field (winning distance).
interface hdc_classify_ctrl_if #(
  parameter int CLS_NUM = 16,
  parameter int DIM     = 1024,
  parameter int WORD_W  = 64
);
  localparam int CLS_DW = $clog2(CLS_NUM);
  localparam int WORDS  = DIM / WORD_W;
  localparam int WRD_DW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DIST_W = $clog2(DIM) + 1;

  logic                           q_valid;
  logic                           q_ready;
  logic                           abort;
  logic                           rd_en;
  logic [CLS_DW-1:0]              rd_cls;
  logic [WRD_DW-1:0]              rd_wrd;
  logic [WORD_W-1:0]              q_data;
  logic [WORD_W-1:0]              c_data;
  logic                           fm_en;
  logic [CLS_NUM-1:0][DIST_W-1:0] fm_nums;
  logic [CLS_DW-1:0]              fm_index;
  logic                           res_valid;
  logic                           res_ready;
  logic [CLS_DW-1:0]              res_cls;
`ifdef HDC_CTRL_DIST_OUT_EN
  logic [DIST_W-1:0]              res_dist;
`endif

  // master: the controller; slave: memories, min-search block and result consumer
  modport master (
    input  q_valid, abort, q_data, c_data, fm_index, res_ready,
    output q_ready, rd_en, rd_cls, rd_wrd, fm_en, fm_nums, res_valid, res_cls
`ifdef HDC_CTRL_DIST_OUT_EN
    , output res_dist
`endif
  );

  modport slave (
    output q_valid, abort, q_data, c_data, fm_index, res_ready,
    input  q_ready, rd_en, rd_cls, rd_wrd, fm_en, fm_nums, res_valid, res_cls
`ifdef HDC_CTRL_DIST_OUT_EN
    , input res_dist
`endif
  );
endinterface

// File: rtl/hdc_classify_ctrl.sv
// HDC inference sequencer: streams query/class words, accumulates Hamming distances,
// runs the external min-search and returns the winner. HDC_CTRL_DIST_OUT_EN adds res_dist.
module hdc_classify_ctrl #(
  parameter int CLS_NUM = 16,
  parameter int DIM     = 1024,
  parameter int WORD_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  hdc_classify_ctrl_if.master bus
);
  localparam int CLS_DW = $clog2(CLS_NUM);
  localparam int WORDS  = DIM / WORD_W;
  localparam int WRD_DW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DIST_W = $clog2(DIM) + 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, SEARCH, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CLS_DW-1:0]   cls_reg;
  logic [WRD_DW-1:0]   wrd_reg;
  logic                rd_en_d_reg;
  logic [CLS_DW-1:0]   cls_d_reg;
  logic [DIST_W-1:0]   dist_reg [CLS_NUM];
  logic [CLS_DW-1:0]   res_cls_reg;
  logic [WORD_W-1:0]   diff;
  logic [DIST_W-1:0]   word_dist;
  logic                accept, clear_cnt, acc_en, last_wrd, last_read;

  assign accept    = (state_reg == IDLE) && bus.q_valid;
  assign clear_cnt = accept || ((state_reg != IDLE) && bus.abort);
  assign last_wrd  = (wrd_reg == WRD_DW'(WORDS - 1));
  assign last_read = last_wrd && (cls_reg == CLS_DW'(CLS_NUM - 1));
  // Returning data belongs to the previous cycle's read; an abort discards it.
  assign acc_en    = rd_en_d_reg && !bus.abort;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.q_ready   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.fm_en     = 1'b0;
    bus.res_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.q_ready = 1'b1;
        if (bus.q_valid) state_next = READ;
      end
      READ: begin
        bus.rd_en = 1'b1;
        if (bus.abort)      state_next = IDLE;
        else if (last_read) state_next = DRAIN;
      end
      DRAIN:  state_next = bus.abort ? IDLE : SEARCH;
      SEARCH: begin
        bus.fm_en  = 1'b1;
        state_next = bus.abort ? IDLE : WAIT;
      end
      WAIT:   state_next = bus.abort ? IDLE : DONE;
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.abort || bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word/class address counters; class advances when the word index wraps.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      cls_reg <= '0;
      wrd_reg <= '0;
    end else if (state_reg == READ) begin
      if (last_wrd) begin
        wrd_reg <= '0;
        cls_reg <= cls_reg + CLS_DW'(1);
      end else begin
        wrd_reg <= wrd_reg + WRD_DW'(1);
      end
    end
  end

  assign bus.rd_cls = cls_reg;
  assign bus.rd_wrd = wrd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_d_reg <= 1'b0;
      cls_d_reg   <= '0;
    end else begin
      rd_en_d_reg <= bus.rd_en && !bus.abort;
      cls_d_reg   <= cls_reg;
    end
  end

  assign diff = bus.q_data ^ bus.c_data;

  always_comb begin
    word_dist = '0;
    for (int i = 0; i < WORD_W; i++) word_dist = word_dist + DIST_W'(diff[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int i = 0; i < CLS_NUM; i++) dist_reg[i] <= '0;
    end else if (acc_en) begin
      dist_reg[cls_d_reg] <= dist_reg[cls_d_reg] + word_dist;
    end
  end

  for (genvar gi = 0; gi < CLS_NUM; gi++) begin : g_fm_nums
    assign bus.fm_nums[gi] = dist_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst)                                    res_cls_reg <= '0;
    else if (state_reg == WAIT && !bus.abort)   res_cls_reg <= bus.fm_index;
  end

  assign bus.res_cls = res_cls_reg;

`ifdef HDC_CTRL_DIST_OUT_EN
  logic [DIST_W-1:0] res_dist_reg;

  always_ff @(posedge clk) begin
    if (rst)                                    res_dist_reg <= '0;
    else if (state_reg == WAIT && !bus.abort)   res_dist_reg <= dist_reg[bus.fm_index];
  end

  assign bus.res_dist = res_dist_reg;
`endif
endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Randomized bench for hdc_classify_ctrl with memory, min-search and result models
// plus a cycle-level expectation built from the query timeline.
module tb_hdc_classify_ctrl;
  localparam int CLS_NUM = 16;
  localparam int DIM     = 1024;
  localparam int WORD_W  = 64;
  localparam int WORDS   = DIM / WORD_W;
  localparam int N       = CLS_NUM * WORDS;
  localparam int CLS_DW  = $clog2(CLS_NUM);
  localparam int DIST_W  = $clog2(DIM) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdc_classify_ctrl_if #(.CLS_NUM(CLS_NUM), .DIM(DIM), .WORD_W(WORD_W)) bus ();

  hdc_classify_ctrl #(.CLS_NUM(CLS_NUM), .DIM(DIM), .WORD_W(WORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Memories with registered read; garbage on the data bus when not reading.
  logic [WORD_W-1:0] qmem [WORDS];
  logic [WORD_W-1:0] cmem [CLS_NUM][WORDS];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.q_data <= qmem[bus.rd_wrd];
      bus.c_data <= cmem[bus.rd_cls][bus.rd_wrd];
    end else begin
      bus.q_data <= {$urandom, $urandom};
      bus.c_data <= {$urandom, $urandom};
    end
  end

  // Min-search block: lowest index wins ties, result one cycle after fm_en.
  logic [CLS_DW-1:0] ms_best;
  always @(posedge clk) begin
    if (bus.fm_en) begin
      ms_best = '0;
      for (int i = 1; i < CLS_NUM; i++)
        if (bus.fm_nums[i] < bus.fm_nums[ms_best]) ms_best = CLS_DW'(i);
      bus.fm_index <= ms_best;
    end else begin
      bus.fm_index <= CLS_DW'($urandom);
    end
  end

  // Reference model: expected distances from the memory contents at accept time.
  int exp_dist [CLS_NUM];
  int exp_cls;

  function automatic void calc_expected();
    for (int c = 0; c < CLS_NUM; c++) begin
      exp_dist[c] = 0;
      for (int w = 0; w < WORDS; w++) exp_dist[c] += $countones(qmem[w] ^ cmem[c][w]);
    end
    exp_cls = 0;
    for (int c = 1; c < CLS_NUM; c++) if (exp_dist[c] < exp_dist[exp_cls]) exp_cls = c;
  endfunction

  int cyc = 0;
  int acc_cyc = 0;
  bit busy = 1'b0;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (rst) busy = 1'b0;
    else if (!busy) begin
      if (bus.q_valid) begin
        busy = 1'b1;
        acc_cyc = cyc;
        calc_expected();
      end
    end else if (bus.abort) busy = 1'b0;
    else if (cyc - acc_cyc >= N + 4 && bus.res_ready) busy = 1'b0;
    cyc++;
    started = 1'b1;
  end

  int t;
  bit exp_rd, exp_fm, exp_rv;

  always @(negedge clk) begin
    if (started) begin
      t      = cyc - acc_cyc;
      exp_rd = busy && t >= 1 && t <= N;
      exp_fm = busy && t == N + 2;
      exp_rv = busy && t >= N + 4;
      chk("q_ready", bus.q_ready, !busy);
      chk("rd_en", bus.rd_en, exp_rd);
      if (exp_rd) begin
        chk("rd_cls", bus.rd_cls, (t - 1) / WORDS);
        chk("rd_wrd", bus.rd_wrd, (t - 1) % WORDS);
      end
      chk("fm_en", bus.fm_en, exp_fm);
      chk("res_valid", bus.res_valid, exp_rv);
      if (busy && (t == N + 2 || t == N + 3))
        for (int i = 0; i < CLS_NUM; i++) chk("fm_nums", bus.fm_nums[i], exp_dist[i]);
      if (exp_rv) begin
        chk("res_cls", bus.res_cls, exp_cls);
`ifdef HDC_CTRL_DIST_OUT_EN
        chk("res_dist", bus.res_dist, exp_dist[exp_cls]);
`endif
      end
    end
  end

  int lat;
  logic [CLS_DW-1:0] got_cls;
  logic [DIST_W-1:0] snap [CLS_NUM];
`ifdef HDC_CTRL_DIST_OUT_EN
  logic [DIST_W-1:0] got_dist;
`endif

  task automatic reset_checks();
    chk("rst_q_ready", bus.q_ready, 1);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_cls", bus.rd_cls, 0);
    chk("rst_rd_wrd", bus.rd_wrd, 0);
    chk("rst_fm_en", bus.fm_en, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_cls", bus.res_cls, 0);
    for (int i = 0; i < CLS_NUM; i++) chk("rst_fm_nums", bus.fm_nums[i], 0);
`ifdef HDC_CTRL_DIST_OUT_EN
    chk("rst_res_dist", bus.res_dist, 0);
`endif
  endtask

  task automatic fill_random(input bit sparse);
    for (int w = 0; w < WORDS; w++) qmem[w] = {$urandom, $urandom};
    for (int c = 0; c < CLS_NUM; c++)
      for (int w = 0; w < WORDS; w++)
        cmem[c][w] = sparse ? (qmem[w] ^ ({$urandom, $urandom} & {$urandom, $urandom}
                                          & {$urandom, $urandom}))
                            : {$urandom, $urandom};
  endtask

  task automatic run_query(input int hold, input bit pulse_q, input bit abort_done);
    int k;
    @(negedge clk);
    bus.q_valid = 1'b1;
    @(negedge clk);
    bus.q_valid = 1'b0;
    k = 1;
    while (!bus.res_valid && k < 1000) begin
      if (bus.fm_en) for (int i = 0; i < CLS_NUM; i++) snap[i] = bus.fm_nums[i];
      @(negedge clk);
      k++;
    end
    lat = k;
    chk("res_valid_wait", bus.res_valid, 1);
    got_cls = bus.res_cls;
`ifdef HDC_CTRL_DIST_OUT_EN
    got_dist = bus.res_dist;
`endif
    for (int h = 0; h < hold; h++) begin
      bus.q_valid = pulse_q && (h == hold / 2);
      chk("hold_res_valid", bus.res_valid, 1);
      chk("hold_res_cls", bus.res_cls, exp_cls);
      chk("hold_q_ready", bus.q_ready, 0);
      @(negedge clk);
    end
    bus.q_valid = 1'b0;
    if (abort_done) bus.abort = 1'b1;
    else            bus.res_ready = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    chk("post_done_q_ready", bus.q_ready, 1);
    chk("post_done_res_valid", bus.res_valid, 0);
  endtask

  bit seen;

  initial begin
    bus.q_valid   = 1'b0;
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    fill_random(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;

    // Query equals class 5
    fill_random(1'b0);
    for (int w = 0; w < WORDS; w++) cmem[5][w] = qmem[w];
    run_query(0, 1'b0, 1'b0);
    chk("t1_latency", lat, N + 4);
    chk("t1_res_cls", got_cls, 5);
`ifdef HDC_CTRL_DIST_OUT_EN
    chk("t1_res_dist", got_dist, 0);
`endif

    // Tie between classes 3 and 9 at distance 10
    fill_random(1'b0);
    for (int w = 0; w < WORDS; w++) begin
      cmem[3][w] = qmem[w];
      cmem[9][w] = (w < 10) ? (qmem[w] ^ 64'd1) : qmem[w];
    end
    cmem[3][0] = qmem[0] ^ 64'h3ff;
    run_query(0, 1'b0, 1'b0);
    chk("t2_tie_cls", got_cls, 3);
    chk("t2_dist3", snap[3], 10);
    chk("t2_dist9", snap[9], 10);

    // Every class is the complement of the query
    fill_random(1'b0);
    for (int c = 0; c < CLS_NUM; c++)
      for (int w = 0; w < WORDS; w++) cmem[c][w] = ~qmem[w];
    run_query(0, 1'b0, 1'b0);
    for (int i = 0; i < CLS_NUM; i++) chk("t3_fm_nums_full", snap[i], DIM);
    chk("t3_res_cls", got_cls, 0);
`ifdef HDC_CTRL_DIST_OUT_EN
    chk("t3_res_dist", got_dist, DIM);
`endif

    // Result back-pressure with an ignored q_valid pulse
    fill_random(1'b1);
    run_query(10, 1'b1, 1'b0);

    // Abort at READ cycle 100, then a clean re-query
    fill_random(1'b0);
    @(negedge clk);
    bus.q_valid = 1'b1;
    @(negedge clk);
    bus.q_valid = 1'b0;
    repeat (99) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_q_ready", bus.q_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      seen |= bus.fm_en | bus.res_valid;
      @(negedge clk);
    end
    chk("abort_no_result", seen, 0);
    fill_random(1'b0);
    for (int w = 0; w < WORDS; w++) cmem[2][w] = qmem[w];
    run_query(0, 1'b0, 1'b0);
    chk("abort_requery_cls", got_cls, 2);
    chk("abort_requery_dist2", snap[2], 0);

    // Synchronous reset mid-READ, then query equal to class 12
    fill_random(1'b0);
    @(negedge clk);
    bus.q_valid = 1'b1;
    @(negedge clk);
    bus.q_valid = 1'b0;
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    rst = 1'b0;
    fill_random(1'b0);
    for (int w = 0; w < WORDS; w++) cmem[12][w] = qmem[w];
    run_query(0, 1'b0, 1'b0);
    chk("rst_requery_cls", got_cls, 12);

    // Randomized queries; one ends with abort in DONE
    for (int r = 0; r < 6; r++) begin
      fill_random(1'b1);
      run_query($urandom_range(0, 5), 1'($urandom_range(0, 1)), r == 3);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
